// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone classic initiator.
package wb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StResp
    } wb_state_e;

    localparam int unsigned DefTimeoutCycles = 16;
    localparam logic [31:0] TimeoutData      = 32'h0000_0000;

endpackage

// File: rtl/wb_initiator_if.sv
// Wishbone classic request/response signal bundle between one master and one slave.
interface wb_initiator_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: command in, one bus cycle with
// bounded ack wait, response out.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_ni,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_we,
    input  logic [31:0]    cmd_adr,
    input  logic [31:0]    cmd_dat,
    input  logic [3:0]     cmd_sel,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [31:0]    rsp_dat,
    output logic           rsp_err,
    wb_initiator_if.master wbm
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

    wb_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StBus;
                    cnt_d   = '0;
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                end
            end
            StBus: begin
                // Ack wins even on the last window cycle.
                if (wbm.wbm_ack_i) begin
                    state_d   = StResp;
                    rsp_dat_d = we_q ? 32'h0 : wbm.wbm_dat_i;
                    rsp_err_d = 1'b0;
                end else begin
                    if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d   = StResp;
                        rsp_dat_d = TimeoutData;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign cmd_ready     = (state_q == StIdle);
    assign rsp_valid     = (state_q == StResp);
    assign rsp_dat       = rsp_dat_q;
    assign rsp_err       = rsp_err_q;
    assign wbm.wbm_cyc_o = (state_q == StBus);
    assign wbm.wbm_stb_o = (state_q == StBus);
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: directed vector table, a reset-mid-bus sequence and
// randomized commands checked against a transaction-level model.
module tb_wb_initiator;

    localparam int unsigned T = 16;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          delay;    // BUS cycle on which the slave acks; 0 = never
        logic [31:0] sdat;
        int          wait_c;   // cycles rsp_ready is held low
        bit          hold;     // keep cmd_valid high until the response is taken
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    int n_vec = 0;
    int n_err = 0;

    wb_initiator_if bus ();

    wb_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm      (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectation: ack inside the window gives a normal response.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.delay >= 1 && v.delay <= int'(T)) begin
            r.exp_dat = v.we ? 32'h0 : v.sdat;
            r.exp_err = 1'b0;
            r.exp_cyc = v.delay;
        end else begin
            r.exp_dat = 32'h0;
            r.exp_err = 1'b1;
            r.exp_cyc = int'(T);
        end
        return r;
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge, idle.
    task automatic run_vec(input vec_t v);
        int k = 0;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
        forever begin
            @(negedge clk);
            if (!v.hold) cmd_valid = 1'b0;
            if (!bus.wbm_stb_o) break;
            k++;
            if (k > int'(T) + 4) begin
                check("bus_cycle_bound", 32'(k), 32'(T));
                break;
            end
            check("bus_adr", bus.wbm_adr_o, v.adr);
            check("bus_dat", bus.wbm_dat_o, v.dat);
            check("bus_we_sel_cyc", {26'h0, bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_sel_o},
                  {26'h0, 1'b1, v.we, v.sel});
            check("cmd_ready_bus", {31'h0, cmd_ready}, 32'h0);
            bus.wbm_ack_i = (k == v.delay);
            bus.wbm_dat_i = bus.wbm_ack_i ? v.sdat : $urandom;
        end
        bus.wbm_ack_i = 1'b0;
        check("stb_cycles", 32'(k), 32'(v.exp_cyc));
        check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("rsp_dat", rsp_dat, v.exp_dat);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, v.exp_err});
        for (int i = 0; i < v.wait_c; i++) begin
            bus.wbm_ack_i = 1'($urandom);
            bus.wbm_dat_i = $urandom;
            @(negedge clk);
            check("rsp_hold_valid", {31'h0, rsp_valid}, 32'h1);
            check("rsp_hold_dat", rsp_dat, v.exp_dat);
            check("rsp_hold_err_ready", {30'h0, rsp_err, cmd_ready}, {30'h0, v.exp_err, 1'b0});
        end
        bus.wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_consumed", {30'h0, rsp_valid, cmd_ready}, 32'h1);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        //            we    adr           dat           sel      dly sdat          wt  hold exp_dat      err  cyc
        tbl[0] = '{1'b0, 32'h3000_0004, 32'h0,        4'b1111, 1,  32'hCAFE_F00D, 0,  0, 32'hCAFE_F00D, 1'b0, 1};
        tbl[1] = '{1'b1, 32'h3000_0000, 32'h1234_5678, 4'b0011, 5,  32'hFFFF_FFFF, 1,  0, 32'h0,        1'b0, 5};
        tbl[2] = '{1'b0, 32'h3000_0008, 32'h0,        4'b1111, 0,  32'hDEAD_BEEF, 0,  0, 32'h0,        1'b1, 16};
        tbl[3] = '{1'b0, 32'h3000_000C, 32'h0,        4'b1100, 16, 32'h5A5A_0F0F, 0,  0, 32'h5A5A_0F0F, 1'b0, 16};
        tbl[4] = '{1'b0, 32'h3000_0010, 32'h0,        4'b0001, 3,  32'h0BAD_CAFE, 10, 1, 32'h0BAD_CAFE, 1'b0, 3};
        tbl[5] = '{1'b1, 32'h3000_0014, 32'hA5A5_A5A5, 4'b1000, 17, 32'h1111_2222, 2,  0, 32'h0,        1'b1, 16};
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;

        #12;
        check("rst_bus_ctl", {29'h0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 32'h0);
        check("rst_bus_adr", bus.wbm_adr_o, 32'h0);
        check("rst_bus_dat_sel", bus.wbm_dat_o | {28'h0, bus.wbm_sel_o}, 32'h0);
        check("rst_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        check("rst_rsp_dat", rsp_dat, 32'h0);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Reset pulse in the middle of a bus cycle drops the transaction.
        cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_bus_stb", {31'h0, bus.wbm_stb_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async_cyc_stb", {30'h0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_idle", {30'h0, rsp_valid, cmd_ready}, 32'h1);
            @(negedge clk);
        end
        run_vec(tbl[0]);

        for (int n = 0; n < 25; n++) begin
            rv.we      = 1'($urandom);
            rv.adr     = $urandom;
            rv.dat     = $urandom;
            rv.sel     = 4'($urandom);
            rv.delay   = int'($urandom_range(0, T + 2));
            rv.sdat    = $urandom;
            rv.wait_c  = int'($urandom_range(0, 3));
            rv.hold    = 1'($urandom);
            rv.exp_dat = '0;
            rv.exp_err = 1'b0;
            rv.exp_cyc = 0;
            run_vec(model(rv));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
